tlb_exp_unit: RTL and testbench
===============================

// Module: tlb_exp_unit
// PURPOSE
//  Parametrised, registered TLB/address exception checker for NCH parallel memory channels.
//  Per channel it yields one prioritised one-hot exception and a kill mask for younger channels.
//  It holds the oldest exception (ecode/esubcode/badv) for the CSR writeback stage until acknowledged.
//  Sits between the TLB lookup stage and the commit/CSR stage; serves both the fetch and LSU paths.
// PARAMETERS
//  NCH    2   number of channels; channel 0 is oldest
//  VA_W   32  virtual address width
//  CNT_W  16  width of the saturating TLBR report counter
//  CH_W   ($clog2(NCH)>0 ? $clog2(NCH) : 1)  channel index width (derived)
// PORTS
//  clk           in   1         clock
//  rst           in   1         asynchronous reset, active-high
//  flush         in   1         pipeline flush; clears output stage and report
//  in_valid      in   1         input bundle valid
//  in_ready      out  1         bundle accepted when in_valid&&in_ready at posedge
//  ch_en         in   NCH       channel carries a real access
//  acc_type      in   2*NCH     per ch: 00 none, 01 fetch, 10 load, 11 store
//  vaddr         in   VA_W*NCH  per-channel virtual address
//  crmd_plv      in   2         current privilege level
//  direct        in   NCH       DA/DMW translation; TLB checks bypassed
//  tlb_found     in   NCH       TLB hit
//  tlb_v         in   NCH       page valid bit
//  tlb_d         in   NCH       page dirty bit
//  tlb_plv       in   2*NCH     page PLV
//  out_valid     out  1         registered result valid
//  out_ready     in   1         downstream consumes result
//  out_exp       out  8*NCH     per-ch one-hot {ADEF,ADEM,TLBR,PIF,PIS,PIL,PPI,PME}, [7]..[0]
//  out_kill      out  NCH       ch is the first excepting channel or younger
//  rpt_valid     out  1         oldest exception held for CSR
//  rpt_ack       in   1         CSR has taken the report
//  rpt_ch        out  CH_W      channel index of the report
//  rpt_ecode     out  6         ADE 0x08, TLBR 0x3F, PIF 0x03, PIS 0x02, PIL 0x01, PPI 0x07, PME 0x04
//  rpt_esubcode  out  9         1 for ADEM, else 0
//  rpt_badv      out  VA_W      vaddr of the reported channel
//  tlbr_cnt      out  CNT_W     count of TLBR reports, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. in_ready reads 1 after reset (combinational).
//  - Per-channel check (comb, only if ch_en && acc_type!=00; otherwise exp=0):
//    1. ADE: vaddr[VA_W-1]==1 && crmd_plv==3 -> ADEF for fetch, ADEM for load/store (also applies when direct=1).
//    2. If direct=1, no further checks.
//    3. !tlb_found -> TLBR. 4. !tlb_v -> PIF/PIL/PIS by access type. 5. crmd_plv>tlb_plv (2-bit unsigned) -> PPI.
//    6. store && !tlb_d -> PME. The first match in this order wins; out_exp per channel is exactly one-hot or zero.
//  - Kill: f = lowest ch with nonzero exp; out_kill[i]=1 for all i>=f; all 0 if none.
//  - Output stage: 1-cycle latency; on accept register out_exp/out_kill and set out_valid=1.
//    out_valid clears on out_ready if nothing accepted in that cycle. Results stay stable while out_valid && !out_ready.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready).
//  - FSM IDLE->REPORT on accepting a bundle with any exception.
//    In the same edge, rpt_ch=f, rpt_ecode/esubcode/badv load from channel f, and rpt_valid=1.
//    REPORT->IDLE on rpt_ack; rpt_valid drops next cycle and rpt_* hold their last values.
//    No input is accepted in REPORT. rpt_ack with rpt_valid=0 is ignored.
//  - tlbr_cnt +1 on each IDLE->REPORT with ecode 0x3F; holds at all-ones; cleared only by rst.
//  - flush (priority over accept and ack): next edge out_valid=0, rpt_valid=0, state IDLE.
//    tlbr_cnt is unchanged, and a bundle offered in the flush cycle is discarded.
//  - rst mid-REPORT: immediate return to reset values.
// TESTING
//  - NCH=2, ch0 load, tlb_found=0 -> next cycle out_exp0=0x20, kill=2'b11, rpt_ecode=0x3F, badv=vaddr0, tlbr_cnt=1.
//  - ch0 clean, ch1 store v=1 d=0 plv ok -> out_exp1=0x01, kill=2'b10, rpt_ch=1, ecode=0x04.
//  - plv=3, ch0 fetch vaddr=0x8000_0000, tlb_found=0 -> ADEF only (0x80), ecode 0x08, esub 0; a load gives ADEM, esub 1.
//  - plv=3, tlb_plv=0, v=1, load -> PPI 0x02, ecode 0x07; direct=1 same access -> no exception, out_kill=0.
//  - Exception held, rpt_ack low 5 cycles -> in_ready=0 throughout; ack -> rpt_valid 0 next cycle, in_ready 1.
//  - flush with the REPORT ack in the same cycle, and offered input -> all valids 0 next edge, no accept, tlbr_cnt held.
//    Preset tlbr_cnt=0xFFFF plus a TLBR report -> stays 0xFFFF.

Source files
------------

// File: rtl/tlb_exp_unit.sv
// rtl/tlb_exp_unit.sv - per-channel TLB/address exception checker with kill mask and held CSR report
module tlb_exp_unit #(
   parameter int NCH   = 2,
   parameter int VA_W  = 32,
   parameter int CNT_W = 16,
   parameter int CH_W  = ($clog2(NCH) > 0) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NCH-1:0]      ch_en,
   input  logic [2*NCH-1:0]    acc_type,
   input  logic [VA_W*NCH-1:0] vaddr,
   input  logic [1:0]          crmd_plv,
   input  logic [NCH-1:0]      direct,
   input  logic [NCH-1:0]      tlb_found,
   input  logic [NCH-1:0]      tlb_v,
   input  logic [NCH-1:0]      tlb_d,
   input  logic [2*NCH-1:0]    tlb_plv,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NCH-1:0]    out_exp,
   output logic [NCH-1:0]      out_kill,
   output logic                rpt_valid,
   input  logic                rpt_ack,
   output logic [CH_W-1:0]     rpt_ch,
   output logic [5:0]          rpt_ecode,
   output logic [8:0]          rpt_esubcode,
   output logic [VA_W-1:0]     rpt_badv,
   output logic [CNT_W-1:0]    tlbr_cnt
);

   typedef enum logic {IDLE, REPORT} state_t;
   state_t state;

   // One-hot priority: {ADEF,ADEM,TLBR,PIF,PIS,PIL,PPI,PME}; first match wins.
   function automatic logic [7:0] check_ch(
      input logic       en,
      input logic [1:0] t,
      input logic       va_msb,
      input logic [1:0] cplv,
      input logic       dir,
      input logic       found,
      input logic       v,
      input logic       d,
      input logic [1:0] pplv
   );
      logic [7:0] e;
      e = 8'h00;
      if (en && t != 2'b00) begin
         if (va_msb && cplv == 2'd3)
            e = (t == 2'b01) ? 8'h80 : 8'h40;
         else if (!dir) begin
            if (!found)
               e = 8'h20;
            else if (!v)
               e = (t == 2'b01) ? 8'h10 : ((t == 2'b11) ? 8'h08 : 8'h04);
            else if (cplv > pplv)
               e = 8'h02;
            else if (t == 2'b11 && !d)
               e = 8'h01;
         end
      end
      return e;
   endfunction

   logic [8*NCH-1:0] exp_c;
   logic [NCH-1:0]   kill_c;
   logic             any_c;
   logic [CH_W-1:0]  first_c;
   logic [7:0]       f_exp;
   logic [VA_W-1:0]  f_va;
   logic [5:0]       ecode_c;
   logic             accept;

   always_comb begin
      exp_c   = '0;
      kill_c  = '0;
      any_c   = 1'b0;
      first_c = '0;
      f_exp   = '0;
      f_va    = '0;
      for (int i = 0; i < NCH; i++) begin
         exp_c[8*i +: 8] = check_ch(ch_en[i], acc_type[2*i +: 2], vaddr[VA_W*i + VA_W - 1],
                                    crmd_plv, direct[i], tlb_found[i], tlb_v[i], tlb_d[i],
                                    tlb_plv[2*i +: 2]);
         if (!any_c && (|exp_c[8*i +: 8])) begin
            any_c   = 1'b1;
            first_c = CH_W'(i);
            f_exp   = exp_c[8*i +: 8];
            f_va    = vaddr[VA_W*i +: VA_W];
         end
         kill_c[i] = any_c;
      end
   end

   always_comb begin
      ecode_c = 6'h00;
      if (f_exp[7] || f_exp[6]) ecode_c = 6'h08;
      else if (f_exp[5])        ecode_c = 6'h3F;
      else if (f_exp[4])        ecode_c = 6'h03;
      else if (f_exp[3])        ecode_c = 6'h02;
      else if (f_exp[2])        ecode_c = 6'h01;
      else if (f_exp[1])        ecode_c = 6'h07;
      else if (f_exp[0])        ecode_c = 6'h04;
   end

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         out_valid    <= 1'b0;
         out_exp      <= '0;
         out_kill     <= '0;
         rpt_valid    <= 1'b0;
         rpt_ch       <= '0;
         rpt_ecode    <= '0;
         rpt_esubcode <= '0;
         rpt_badv     <= '0;
         tlbr_cnt     <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_exp   <= '0;
         out_kill  <= '0;
         rpt_valid <= 1'b0;
      end else begin
         if (accept) begin
            out_exp   <= exp_c;
            out_kill  <= kill_c;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept && any_c) begin
                  state        <= REPORT;
                  rpt_valid    <= 1'b1;
                  rpt_ch       <= first_c;
                  rpt_ecode    <= ecode_c;
                  rpt_esubcode <= {8'h00, f_exp[6]};
                  rpt_badv     <= f_va;
                  if (ecode_c == 6'h3F && tlbr_cnt != '1)
                     tlbr_cnt <= tlbr_cnt + CNT_W'(1);
               end
            end
            REPORT: begin
               // rpt_* fields keep their values after the ack for late readers.
               if (rpt_ack) begin
                  state     <= IDLE;
                  rpt_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_exp_unit.sv
// tb/tb_tlb_exp_unit.sv - directed self-checking bench for tlb_exp_unit
module tb_tlb_exp_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ch_en;
   logic [3:0]  acc_type;
   logic [63:0] vaddr;
   logic [1:0]  crmd_plv;
   logic [1:0]  direct;
   logic [1:0]  tlb_found;
   logic [1:0]  tlb_v;
   logic [1:0]  tlb_d;
   logic [3:0]  tlb_plv;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_exp;
   logic [1:0]  out_kill;
   logic        rpt_valid;
   logic        rpt_ack;
   logic [0:0]  rpt_ch;
   logic [5:0]  rpt_ecode;
   logic [8:0]  rpt_esubcode;
   logic [31:0] rpt_badv;
   logic [3:0]  tlbr_cnt;

   int checks = 0;
   int errors = 0;

   // Narrow counter so saturation is reachable in a short run.
   tlb_exp_unit #(.NCH(2), .VA_W(32), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .ch_en(ch_en), .acc_type(acc_type), .vaddr(vaddr), .crmd_plv(crmd_plv),
      .direct(direct), .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d),
      .tlb_plv(tlb_plv), .out_valid(out_valid), .out_ready(out_ready),
      .out_exp(out_exp), .out_kill(out_kill), .rpt_valid(rpt_valid), .rpt_ack(rpt_ack),
      .rpt_ch(rpt_ch), .rpt_ecode(rpt_ecode), .rpt_esubcode(rpt_esubcode),
      .rpt_badv(rpt_badv), .tlbr_cnt(tlbr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ch_en = '0; acc_type = '0; vaddr = '0; direct = '0;
      tlb_found = '0; tlb_v = '0; tlb_d = '0; tlb_plv = '0; crmd_plv = 2'd0;
   endtask

   task automatic set_ch(input int i, input logic [1:0] t, input logic [31:0] va,
                         input logic dir, input logic found, input logic v,
                         input logic d, input logic [1:0] pp);
      ch_en[i] = 1'b1;
      acc_type[2*i +: 2] = t;
      vaddr[32*i +: 32] = va;
      direct[i] = dir;
      tlb_found[i] = found;
      tlb_v[i] = v;
      tlb_d[i] = d;
      tlb_plv[2*i +: 2] = pp;
   endtask

   task automatic offer();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic ack();
      rpt_ack = 1'b1;
      tick();
      rpt_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rpt_ack = 1'b0;
      clr();
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_tlbr_cnt", 64'(tlbr_cnt), 64'd0);
      chk("rst_out_exp", 64'(out_exp), 64'd0);

      // TLBR on ch0 load
      clr();
      set_ch(0, 2'b10, 32'h1000_0040, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      offer();
      chk("tlbr_out_valid", 64'(out_valid), 64'd1);
      chk("tlbr_out_exp", 64'(out_exp), 64'h0020);
      chk("tlbr_kill", 64'(out_kill), 64'h3);
      chk("tlbr_rpt_valid", 64'(rpt_valid), 64'd1);
      chk("tlbr_ecode", 64'(rpt_ecode), 64'h3F);
      chk("tlbr_badv", 64'(rpt_badv), 64'h1000_0040);
      chk("tlbr_rpt_ch", 64'(rpt_ch), 64'd0);
      chk("tlbr_cnt1", 64'(tlbr_cnt), 64'd1);
      chk("tlbr_in_ready", 64'(in_ready), 64'd0);
      ack();
      chk("ack_rpt_valid", 64'(rpt_valid), 64'd0);
      chk("ack_in_ready", 64'(in_ready), 64'd1);
      chk("ack_ecode_hold", 64'(rpt_ecode), 64'h3F);
      chk("ack_out_valid", 64'(out_valid), 64'd0);

      // PME on ch1 store, ch0 clean
      clr();
      set_ch(0, 2'b10, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
      set_ch(1, 2'b11, 32'h2000_0100, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      offer();
      chk("pme_out_exp", 64'(out_exp), 64'h0100);
      chk("pme_kill", 64'(out_kill), 64'h2);
      chk("pme_rpt_ch", 64'(rpt_ch), 64'd1);
      chk("pme_ecode", 64'(rpt_ecode), 64'h04);
      chk("pme_badv", 64'(rpt_badv), 64'h2000_0100);
      ack();

      // ADEF beats TLBR at PLV3; then ADEM for a load
      clr();
      crmd_plv = 2'd3;
      set_ch(0, 2'b01, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      offer();
      chk("adef_out_exp", 64'(out_exp), 64'h0080);
      chk("adef_ecode", 64'(rpt_ecode), 64'h08);
      chk("adef_esub", 64'(rpt_esubcode), 64'd0);
      chk("adef_cnt_held", 64'(tlbr_cnt), 64'd1);
      ack();
      acc_type[1:0] = 2'b10;
      offer();
      chk("adem_out_exp", 64'(out_exp), 64'h0040);
      chk("adem_ecode", 64'(rpt_ecode), 64'h08);
      chk("adem_esub", 64'(rpt_esubcode), 64'd1);
      ack();

      // PPI, then the same access with direct translation
      clr();
      crmd_plv = 2'd3;
      set_ch(0, 2'b10, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
      offer();
      chk("ppi_out_exp", 64'(out_exp), 64'h0002);
      chk("ppi_ecode", 64'(rpt_ecode), 64'h07);
      ack();
      direct[0] = 1'b1;
      offer();
      chk("direct_out_valid", 64'(out_valid), 64'd1);
      chk("direct_out_exp", 64'(out_exp), 64'h0000);
      chk("direct_kill", 64'(out_kill), 64'h0);
      chk("direct_rpt_valid", 64'(rpt_valid), 64'd0);
      tick();
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      // Report held while ack low; extra offers are refused
      clr();
      set_ch(0, 2'b10, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      out_ready = 1'b0;
      offer();
      chk("hold_cnt2", 64'(tlbr_cnt), 64'd2);
      clr();
      set_ch(1, 2'b11, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("hold_rpt_valid", 64'(rpt_valid), 64'd1);
         chk("hold_out_exp", 64'(out_exp), 64'h0020);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      ack();
      chk("hold_ack_rpt_valid", 64'(rpt_valid), 64'd0);
      chk("hold_ack_in_ready", 64'(in_ready), 64'd1);

      // Flush with ack and an offered bundle in REPORT
      clr();
      set_ch(0, 2'b01, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      offer();
      chk("fl_cnt3", 64'(tlbr_cnt), 64'd3);
      clr();
      set_ch(1, 2'b11, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
      flush = 1'b1; rpt_ack = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; rpt_ack = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_rpt_valid", 64'(rpt_valid), 64'd0);
      chk("fl_cnt_held", 64'(tlbr_cnt), 64'd3);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      // Flush in IDLE discards the offered bundle
      clr();
      set_ch(0, 2'b10, 32'h0000_6000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      flush = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_idle_out_valid", 64'(out_valid), 64'd0);
      chk("fl_idle_rpt_valid", 64'(rpt_valid), 64'd0);
      chk("fl_idle_cnt", 64'(tlbr_cnt), 64'd3);

      // Saturation of the 4-bit counter at 15
      for (int k = 0; k < 12; k++) begin
         offer();
         ack();
      end
      chk("sat_cnt15", 64'(tlbr_cnt), 64'd15);
      offer();
      chk("sat_cnt_hold", 64'(tlbr_cnt), 64'd15);
      chk("sat_rpt_valid", 64'(rpt_valid), 64'd1);

      // Asynchronous reset while in REPORT
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rpt_valid", 64'(rpt_valid), 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_cnt", 64'(tlbr_cnt), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      tick();
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
